// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-master AXI4-Lite bus arbiter.
// Grant codes double as the owner/target select seen by SRAM and UART.
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'b00,
      INSTMEM = 2'b01,
      DATAMEM = 2'b10,
      UART    = 2'b11
   } grant_t;

   localparam int ACERR_WIDTH = 2;
   localparam logic [ACERR_WIDTH-1:0] OKAY   = 2'b00;
   localparam logic [ACERR_WIDTH-1:0] DECERR = 2'b11;

   localparam int NUM_ARB_MASTERS = 2;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      ERR  = 2'b10
   } state_t;

   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } op_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Master, slave and grant signals around the arbiter.
// The slave modport is the arbiter's own view of the bus.
interface mem_bus_arbiter_if
   import mem_bus_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) ();

   logic [DATA_WIDTH-1:0]  i_araddr;
   logic                   i_arvalid;
   logic                   i_rready;
   logic                   i_arready;
   logic                   i_rvalid;
   logic [DATA_WIDTH-1:0]  i_rdata;
   logic [ACERR_WIDTH-1:0] i_rresp;

   logic [DATA_WIDTH-1:0]  d_araddr;
   logic                   d_arvalid;
   logic                   d_rready;
   logic [DATA_WIDTH-1:0]  d_awaddr;
   logic                   d_awvalid;
   logic                   d_wvalid;
   logic                   d_bready;
   logic                   d_arready;
   logic                   d_rvalid;
   logic [DATA_WIDTH-1:0]  d_rdata;
   logic [ACERR_WIDTH-1:0] d_rresp;
   logic                   d_awready;
   logic                   d_wready;
   logic                   d_bvalid;
   logic [ACERR_WIDTH-1:0] d_bresp;

   logic                   s_aready;
   logic                   s_rvalid;
   logic [DATA_WIDTH-1:0]  s_rdata;
   logic [ACERR_WIDTH-1:0] s_rresp;
   logic                   s_awready;
   logic                   s_wready;
   logic                   s_bvalid;
   logic [ACERR_WIDTH-1:0] s_bresp;

   logic                   u_aready;
   logic                   u_rvalid;
   logic [DATA_WIDTH-1:0]  u_rdata;
   logic [ACERR_WIDTH-1:0] u_rresp;
   logic                   u_awready;
   logic                   u_wready;
   logic                   u_bvalid;
   logic [ACERR_WIDTH-1:0] u_bresp;

   grant_t                 grant;

   modport slave (
      input  i_araddr, i_arvalid, i_rready,
      output i_arready, i_rvalid, i_rdata, i_rresp,
      input  d_araddr, d_arvalid, d_rready,
      input  d_awaddr, d_awvalid, d_wvalid, d_bready,
      output d_arready, d_rvalid, d_rdata, d_rresp,
      output d_awready, d_wready, d_bvalid, d_bresp,
      input  s_aready, s_rvalid, s_rdata, s_rresp,
      input  s_awready, s_wready, s_bvalid, s_bresp,
      input  u_aready, u_rvalid, u_rdata, u_rresp,
      input  u_awready, u_wready, u_bvalid, u_bresp,
      output grant
   );

   modport master (
      output i_araddr, i_arvalid, i_rready,
      input  i_arready, i_rvalid, i_rdata, i_rresp,
      output d_araddr, d_arvalid, d_rready,
      output d_awaddr, d_awvalid, d_wvalid, d_bready,
      input  d_arready, d_rvalid, d_rdata, d_rresp,
      input  d_awready, d_wready, d_bvalid, d_bresp,
      output s_aready, s_rvalid, s_rdata, s_rresp,
      output s_awready, s_wready, s_bvalid, s_bresp,
      output u_aready, u_rvalid, u_rdata, u_rresp,
      output u_awready, u_wready, u_bvalid, u_bresp,
      input  grant
   );

endinterface

// File: rtl/mem_bus_addr_decode.sv
// Maps an LSU byte address to its slave: the UART window or data SRAM.
// Compared one bit wider so a window touching the top of memory cannot wrap.
module mem_bus_addr_decode
   import mem_bus_arbiter_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] UART_BASE  = 32'ha000_03f8,
   parameter logic [DATA_WIDTH-1:0] UART_SIZE  = 32'h8
) (
   input  logic [DATA_WIDTH-1:0] addr_i,
   output grant_t                tgt_o
);

   logic [DATA_WIDTH:0] addr_x;
   logic [DATA_WIDTH:0] lo_x;
   logic [DATA_WIDTH:0] hi_x;

   assign addr_x = {1'b0, addr_i};
   assign lo_x   = {1'b0, UART_BASE};
   assign hi_x   = lo_x + {1'b0, UART_SIZE};

   assign tgt_o = (addr_x >= lo_x && addr_x < hi_x)
                ? UART : DATAMEM;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (IFU/LSU) AXI4-Lite arbiter in front of SRAM and UART.
// Owns a registered grant, routes responses, and forces DECERR on timeout.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int                    DATA_WIDTH     = 32,
   parameter logic [DATA_WIDTH-1:0] UART_BASE      = 32'ha000_03f8,
   parameter logic [DATA_WIDTH-1:0] UART_SIZE      = 32'h8,
   parameter int                    TIMEOUT_CYCLES = 256
) (
   input logic              clk,
   input logic              rstn,
   mem_bus_arbiter_if.slave bus
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   state_t  state_q, state_d;
   grant_t  grant_q, grant_d;
   grant_t  last_q, last_d;
   op_t     op_q, op_d;
   logic    lsu_q, lsu_d;
   logic    uart_q, uart_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [DATA_WIDTH-1:0] d_addr;
   grant_t                d_tgt;

   logic                   t_aready;
   logic                   t_rvalid;
   logic [DATA_WIDTH-1:0]  t_rdata;
   logic [ACERR_WIDTH-1:0] t_rresp;
   logic                   t_awready;
   logic                   t_wready;
   logic                   t_bvalid;
   logic [ACERR_WIDTH-1:0] t_bresp;

   logic ireq, dreq, pick_lsu;
   logic own_rready, done, err_ack;
   logic unused_sig;

   assign unused_sig = ^{bus.i_araddr, bus.d_wvalid};

   // The write address wins the decode when both LSU channels are up.
   assign d_addr = bus.d_awvalid ? bus.d_awaddr : bus.d_araddr;

   mem_bus_addr_decode #(
      .DATA_WIDTH (DATA_WIDTH),
      .UART_BASE  (UART_BASE),
      .UART_SIZE  (UART_SIZE)
   ) u_dec (
      .addr_i (d_addr),
      .tgt_o  (d_tgt)
   );

   always_comb begin
      t_aready  = bus.s_aready;
      t_rvalid  = bus.s_rvalid;
      t_rdata   = bus.s_rdata;
      t_rresp   = bus.s_rresp;
      t_awready = bus.s_awready;
      t_wready  = bus.s_wready;
      t_bvalid  = bus.s_bvalid;
      t_bresp   = bus.s_bresp;
      if (uart_q) begin
         t_aready  = bus.u_aready;
         t_rvalid  = bus.u_rvalid;
         t_rdata   = bus.u_rdata;
         t_rresp   = bus.u_rresp;
         t_awready = bus.u_awready;
         t_wready  = bus.u_wready;
         t_bvalid  = bus.u_bvalid;
         t_bresp   = bus.u_bresp;
      end
   end

   assign ireq       = bus.i_arvalid;
   assign dreq       = bus.d_arvalid | bus.d_awvalid;
   assign own_rready = lsu_q ? bus.d_rready : bus.i_rready;
   assign done       = (op_q == WRITE) ? (t_bvalid & bus.d_bready)
                                       : (t_rvalid & own_rready);
   assign err_ack    = (op_q == WRITE) ? bus.d_bready : own_rready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         grant_q <= EMPTY;
         last_q  <= DATAMEM;
         op_q    <= READ;
         lsu_q   <= 1'b0;
         uart_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         op_q    <= op_d;
         lsu_q   <= lsu_d;
         uart_q  <= uart_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      last_d   = last_q;
      op_d     = op_q;
      lsu_d    = lsu_q;
      uart_d   = uart_q;
      cnt_d    = cnt_q;
      pick_lsu = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ireq | dreq) begin
               // Under contention the previous owner yields.
               pick_lsu = dreq & (~ireq | (last_q == INSTMEM));
               lsu_d    = pick_lsu;
               op_d     = (pick_lsu & bus.d_awvalid) ? WRITE : READ;
               uart_d   = pick_lsu & (d_tgt == UART);
               grant_d  = pick_lsu ? d_tgt : INSTMEM;
               cnt_d    = '0;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            if (done) begin
               grant_d = EMPTY;
               last_d  = lsu_q ? DATAMEM : INSTMEM;
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               grant_d = EMPTY;
               state_d = ERR;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ERR: begin
            if (err_ack) begin
               last_d  = lsu_q ? DATAMEM : INSTMEM;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.i_arready = 1'b0;
      bus.i_rvalid  = 1'b0;
      bus.i_rdata   = '0;
      bus.i_rresp   = OKAY;
      bus.d_arready = 1'b0;
      bus.d_rvalid  = 1'b0;
      bus.d_rdata   = '0;
      bus.d_rresp   = OKAY;
      bus.d_awready = 1'b0;
      bus.d_wready  = 1'b0;
      bus.d_bvalid  = 1'b0;
      bus.d_bresp   = OKAY;
      unique case (state_q)
         BUSY: begin
            if (lsu_q) begin
               bus.d_arready = t_aready;
               bus.d_rvalid  = t_rvalid;
               bus.d_rdata   = t_rdata;
               bus.d_rresp   = t_rresp;
               bus.d_awready = t_awready;
               bus.d_wready  = t_wready;
               bus.d_bvalid  = t_bvalid;
               bus.d_bresp   = t_bresp;
            end else begin
               bus.i_arready = t_aready;
               bus.i_rvalid  = t_rvalid;
               bus.i_rdata   = t_rdata;
               bus.i_rresp   = t_rresp;
            end
         end
         ERR: begin
            if (!lsu_q) begin
               bus.i_rvalid = 1'b1;
               bus.i_rresp  = DECERR;
            end else if (op_q == WRITE) begin
               bus.d_bvalid = 1'b1;
               bus.d_bresp  = DECERR;
            end else begin
               bus.d_rvalid = 1'b1;
               bus.d_rresp  = DECERR;
            end
         end
         default: begin
         end
      endcase
   end

   assign bus.grant = grant_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a transaction-level model
// checked every cycle, plus hand-computed grant/response checkpoints.
module tb_mem_bus_arbiter;
   import mem_bus_arbiter_pkg::*;

   localparam int TO = 8;

   logic clk = 1'b0;
   logic rstn;
   int   total = 0;
   int   bad   = 0;

   mem_bus_arbiter_if #(.DATA_WIDTH(32)) bus ();

   mem_bus_arbiter #(
      .DATA_WIDTH     (32),
      .UART_BASE      (32'ha000_03f8),
      .UART_SIZE      (32'h8),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   // Model: one in-flight transaction record.
   bit m_act, m_err, m_lsu, m_wr, m_uart, m_last_lsu;
   int m_age;

   function automatic bit in_uart(input logic [31:0] a);
      return a >= 32'ha000_03f8 && a <= 32'ha000_03ff;
   endfunction

   always @(posedge clk or negedge rstn) begin
      bit rv, bv, dreq, take_lsu, fin;
      if (!rstn) begin
         m_act = 0; m_err = 0; m_lsu = 0;
         m_wr = 0; m_uart = 0; m_age = 0;
         m_last_lsu = 1;
      end else if (!m_act) begin
         dreq = bus.d_arvalid || bus.d_awvalid;
         if (bus.i_arvalid || dreq) begin
            take_lsu = dreq && (!bus.i_arvalid || !m_last_lsu);
            m_lsu  = take_lsu;
            m_wr   = take_lsu && bus.d_awvalid;
            m_uart = take_lsu && in_uart(bus.d_awvalid ?
                                         bus.d_awaddr : bus.d_araddr);
            m_act = 1; m_err = 0; m_age = 0;
         end
      end else if (!m_err) begin
         m_age++;
         rv = m_uart ? bus.u_rvalid : bus.s_rvalid;
         bv = m_uart ? bus.u_bvalid : bus.s_bvalid;
         if (m_wr) fin = bv && bus.d_bready;
         else fin = rv && (m_lsu ? bus.d_rready : bus.i_rready);
         if (fin) begin
            m_act = 0; m_last_lsu = m_lsu;
         end else if (m_age == TO) begin
            m_err = 1;
         end
      end else begin
         if (m_wr) fin = bus.d_bready;
         else fin = m_lsu ? bus.d_rready : bus.i_rready;
         if (fin) begin
            m_act = 0; m_err = 0; m_last_lsu = m_lsu;
         end
      end
   end

   function automatic logic [78:0] expect_out();
      logic ar, rv, aw, wv, bv;
      logic [31:0] rd;
      logic [1:0]  rr, br, g;
      logic [35:0] iv;
      logic [40:0] dv;
      iv = '0; dv = '0; g = 2'd0;
      ar = m_uart ? bus.u_aready  : bus.s_aready;
      rv = m_uart ? bus.u_rvalid  : bus.s_rvalid;
      rd = m_uart ? bus.u_rdata   : bus.s_rdata;
      rr = m_uart ? bus.u_rresp   : bus.s_rresp;
      aw = m_uart ? bus.u_awready : bus.s_awready;
      wv = m_uart ? bus.u_wready  : bus.s_wready;
      bv = m_uart ? bus.u_bvalid  : bus.s_bvalid;
      br = m_uart ? bus.u_bresp   : bus.s_bresp;
      if (m_act && !m_err) begin
         g = !m_lsu ? 2'd1 : (m_uart ? 2'd3 : 2'd2);
         if (m_lsu) dv = {ar, rv, rd, rr, aw, wv, bv, br};
         else iv = {ar, rv, rd, rr};
      end else if (m_act) begin
         if (!m_lsu) iv = {2'b01, 32'h0, 2'b11};
         else if (m_wr) dv = {36'h0, 3'b001, 2'b11};
         else dv = {2'b01, 32'h0, 2'b11, 5'h0};
      end
      return {iv, dv, g};
   endfunction

   function automatic logic [78:0] actual_out();
      return {bus.i_arready, bus.i_rvalid, bus.i_rdata, bus.i_rresp,
              bus.d_arready, bus.d_rvalid, bus.d_rdata, bus.d_rresp,
              bus.d_awready, bus.d_wready, bus.d_bvalid, bus.d_bresp,
              2'(bus.grant)};
   endfunction

   always @(negedge clk) begin
      logic [78:0] a, e;
      a = actual_out();
      e = expect_out();
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL cycle_cmp t=%0t got=%h want=%h", $time, a, e);
      end
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   task automatic clear_inputs();
      bus.i_araddr = '0; bus.i_arvalid = 0; bus.i_rready = 0;
      bus.d_araddr = '0; bus.d_arvalid = 0; bus.d_rready = 0;
      bus.d_awaddr = '0; bus.d_awvalid = 0; bus.d_wvalid = 0;
      bus.d_bready = 0;
      bus.s_aready = 0; bus.s_rvalid = 0; bus.s_rdata = '0;
      bus.s_rresp = 0; bus.s_awready = 0; bus.s_wready = 0;
      bus.s_bvalid = 0; bus.s_bresp = 0;
      bus.u_aready = 0; bus.u_rvalid = 0; bus.u_rdata = '0;
      bus.u_rresp = 0; bus.u_awready = 0; bus.u_wready = 0;
      bus.u_bvalid = 0; bus.u_bresp = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0;
      clear_inputs();
      #1;
      chk("rst_grant", 64'(bus.grant), 0);
      chk("rst_outs", 64'(actual_out()), 0);
      do_reset();

      // IFU alone, SRAM answers three cycles later
      bus.i_araddr = 32'h8000_0000; bus.i_arvalid = 1; bus.i_rready = 1;
      tick();
      chk("ifu_grant", 64'(bus.grant), 1);
      bus.s_aready = 1;
      #1 chk("ifu_arready", 64'(bus.i_arready), 1);
      tick();
      bus.i_arvalid = 0; bus.s_aready = 0;
      tick(); tick();
      bus.s_rvalid = 1; bus.s_rdata = 32'hDEAD_BEEF;
      #1 chk("ifu_rdata", 64'(bus.i_rdata), 64'hDEAD_BEEF);
      chk("ifu_rresp", 64'(bus.i_rresp), 0);
      tick();
      chk("ifu_release", 64'(bus.grant), 0);
      bus.s_rvalid = 0;
      tick();

      // Contention right after reset: IFU, LSU, IFU
      do_reset();
      bus.i_araddr = 32'h8000_0010; bus.i_arvalid = 1; bus.i_rready = 1;
      bus.d_araddr = 32'h8000_0100; bus.d_arvalid = 1; bus.d_rready = 1;
      tick();
      chk("arb1_ifu", 64'(bus.grant), 1);
      bus.s_rvalid = 1; bus.s_rdata = 32'h1111_0001;
      tick();
      chk("arb1_gap", 64'(bus.grant), 0);
      bus.s_rvalid = 0;
      tick();
      chk("arb2_lsu", 64'(bus.grant), 2);
      bus.s_rvalid = 1; bus.s_rdata = 32'h2222_0002;
      tick();
      chk("arb2_gap", 64'(bus.grant), 0);
      bus.s_rvalid = 0;
      tick();
      chk("arb3_ifu", 64'(bus.grant), 1);
      bus.s_rvalid = 1; bus.i_arvalid = 0; bus.d_arvalid = 0;
      tick();
      bus.s_rvalid = 0;
      tick();

      // LSU write to the UART, SRAM write channel driven as noise
      bus.d_awaddr = 32'ha000_03f8; bus.d_awvalid = 1;
      bus.d_wvalid = 1; bus.d_bready = 1;
      bus.s_awready = 1; bus.s_wready = 1;
      bus.s_bvalid = 1; bus.s_bresp = 2'b10;
      tick();
      chk("uart_grant", 64'(bus.grant), 3);
      bus.u_awready = 1; bus.u_wready = 1;
      #1 chk("uart_awready", 64'({bus.d_awready, bus.d_wready}), 3);
      tick();
      bus.u_awready = 0; bus.u_wready = 0;
      bus.d_awvalid = 0; bus.d_wvalid = 0;
      bus.u_bvalid = 1; bus.u_bresp = 0;
      #1 chk("uart_bresp", 64'({bus.d_bvalid, bus.d_bresp}), 4);
      tick();
      chk("uart_release", 64'(bus.grant), 0);
      bus.u_bvalid = 0;
      bus.s_awready = 0; bus.s_wready = 0;
      bus.s_bvalid = 0; bus.s_bresp = 0;
      tick();

      // LSU read and write together: write first, read next
      bus.d_araddr = 32'h8000_0200; bus.d_arvalid = 1;
      bus.d_awaddr = 32'h8000_0300; bus.d_awvalid = 1;
      bus.d_rready = 1; bus.d_bready = 1;
      tick();
      chk("rw_wr_grant", 64'(bus.grant), 2);
      bus.s_rvalid = 1; bus.s_rdata = 32'h0000_1234;
      tick();
      chk("rw_is_write", 64'(bus.grant), 2);
      bus.s_rvalid = 0; bus.s_bvalid = 1;
      tick();
      chk("rw_wr_done", 64'(bus.grant), 0);
      bus.d_awvalid = 0; bus.s_bvalid = 0;
      tick();
      chk("rw_rd_grant", 64'(bus.grant), 2);
      bus.s_rvalid = 1;
      tick();
      chk("rw_rd_done", 64'(bus.grant), 0);
      bus.d_arvalid = 0; bus.s_rvalid = 0;
      tick();

      // Silent slave: DECERR after TO busy cycles
      bus.d_araddr = 32'h8000_0400; bus.d_arvalid = 1; bus.d_rready = 0;
      tick();
      chk("to_grant", 64'(bus.grant), 2);
      bus.d_arvalid = 0;
      repeat (TO - 1) tick();
      chk("to_last_busy", 64'(bus.grant), 2);
      tick();
      chk("to_grant_off", 64'(bus.grant), 0);
      chk("to_err_resp",
          64'({bus.d_rvalid, bus.d_rresp, bus.d_rdata}),
          {31'h0, 1'b1, 2'b11, 32'h0});
      tick(); tick();
      chk("to_err_hold", 64'(bus.d_rvalid), 1);
      bus.d_rready = 1;
      tick();
      chk("to_err_done", 64'(bus.d_rvalid), 0);
      tick();

      // Completion on the timeout cycle itself is a normal finish
      bus.d_araddr = 32'h8000_0500; bus.d_arvalid = 1;
      tick();
      bus.d_arvalid = 0;
      repeat (TO - 1) tick();
      chk("edge_busy", 64'(bus.grant), 2);
      bus.s_rvalid = 1; bus.s_rdata = 32'h0000_CAFE;
      #1 chk("edge_rdata", 64'(bus.d_rdata), 64'hCAFE);
      tick();
      chk("edge_no_err", 64'({bus.grant, bus.d_rvalid}), 0);
      bus.s_rvalid = 0; bus.d_rready = 0;
      tick();

      // Asynchronous reset in the middle of an IFU read
      bus.i_araddr = 32'h8000_0600; bus.i_arvalid = 1; bus.i_rready = 1;
      tick();
      chk("ar_grant", 64'(bus.grant), 1);
      bus.s_aready = 1;
      #1 chk("ar_arready", 64'(bus.i_arready), 1);
      #1 rstn = 1'b0;
      #1 chk("ar_async", 64'({bus.grant, bus.i_arready}), 0);
      @(negedge clk);
      #1 rstn = 1'b1;
      bus.s_aready = 0;
      tick();
      chk("ar_regrant", 64'(bus.grant), 1);
      bus.s_rvalid = 1; bus.s_rdata = 32'h600D_F00D; bus.i_arvalid = 0;
      tick();
      chk("ar_release", 64'(bus.grant), 0);
      bus.s_rvalid = 0;
      tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master, two-slave AXI4-Lite arbiter. It sits directly upstream of the SRAM slave and the UART slave.
- Masters: IFU (read-only, i_* channel) and LSU (read/write, d_* channel).
- Produces the registered `grant` code that SRAM/UART use to select their master.
- Routes the selected slave's ready/valid/data back to the owning master.
- Releases the bus when a transaction completes or times out.

Parameters:
DATA_WIDTH, 32, address/data width
UART_BASE, 32'ha000_03f8, first UART byte address
UART_SIZE, 32'h8, UART window size in bytes
TIMEOUT_CYCLES, 256, cycles of ownership before a forced error response (>=2)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
i_araddr/i_arvalid/i_rready  in  32/1/1  IFU request side
i_arready/i_rvalid/i_rdata/i_rresp  out  1/1/32/2  IFU response side
d_araddr/d_arvalid/d_rready/d_awaddr/d_awvalid/d_wvalid/d_bready  in  32/1/1/32/1/1/1  LSU request side
d_arready/d_rvalid/d_rdata/d_rresp/d_awready/d_wready/d_bvalid/d_bresp  out  1/1/32/2/1/1/1/2  LSU response side
s_aready/s_rvalid/s_rdata/s_rresp/s_awready/s_wready/s_bvalid/s_bresp  in  1/1/32/2/1/1/1/2  SRAM responses
u_aready/u_rvalid/u_rdata/u_rresp/u_awready/u_wready/u_bvalid/u_bresp  in  same  UART responses
grant  out  2  registered owner code: EMPTY/INSTMEM/DATAMEM/UART

Behaviour:
- Reset, asynchronous on rstn low:
  - state=IDLE, grant=EMPTY, last_owner=DATAMEM, timeout counter=0, op latch=READ.
  - All master-facing outputs are 0.
- Requests:
  - ireq = i_arvalid.
  - dreq = d_arvalid | d_awvalid.
  - An LSU request is a write if d_awvalid=1, else a read. Write wins if both are high; the read is re-arbitrated after the write completes.
- IDLE:
  - Only one request pending: grant that master.
  - Both pending: grant the master not equal to last_owner (alternating fairness).
  - LSU target: decode the write address if d_awvalid is high, otherwise the read address. Address in [UART_BASE, UART_BASE+UART_SIZE) → UART, else DATAMEM.
  - grant, op (READ/WRITE), owner and target are latched on the same edge; state→BUSY; counter cleared.
  - grant is visible the cycle after the request is sampled. No grant change ever occurs while BUSY or ERR.
- BUSY:
  - Combinationally route the target slave's responses to the owner's outputs.
  - Non-owner master outputs, and the unused slave's signals, are forced to 0.
  - Read completes on owner rvalid & rready. Write completes on d_bvalid & d_bready.
  - On completion: grant→EMPTY, last_owner←owner, state→IDLE. A new grant is allowed no earlier than the following edge, so there is one IDLE cycle between owners.
- Timeout:
  - The counter increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES-1 without completion: state→ERR, grant→EMPTY, slave routing cut off.
- ERR:
  - Arbiter drives owner rvalid=1 with rresp=2'b11 (read) or bvalid=1 with bresp=2'b11 (write); data=0.
  - Holds until the matching ready, then →IDLE and last_owner updated.
- A completion on exactly the timeout cycle counts as a normal completion; no error is issued.
- Reset mid-transaction aborts immediately. No response is owed after reset.
- Master valids that drop mid-transaction are ignored; ownership persists until completion or timeout.

Decomposition:
- Shared package/header holds:
  - grant codes: EMPTY=2'b00, INSTMEM=2'b01, DATAMEM=2'b10, UART=2'b11
  - ACERR_WIDTH=2; resp codes OKAY=2'b00, DECERR=2'b11
  - NUM_ARB_MASTERS=2
  - FSM state encoding: IDLE/BUSY/ERR
- One natural sub-module: mem_bus_addr_decode (combinational address → target code). The response mux stays inline.

Test Plan:
- IFU only, i_araddr=0x8000_0000; SRAM returns rdata=0xDEADBEEF with rvalid 3 cycles later → grant=01 one cycle after arvalid; i_rdata=0xDEADBEEF, i_rresp=0; grant=00 the cycle after the rvalid&rready handshake.
- IFU and LSU read asserted the same cycle after reset → IFU granted first (last_owner=DATAMEM); LSU granted after one IDLE cycle; third contention round goes to IFU again.
- LSU write to 0xa000_03f8 with data 0x41 → grant=11; UART awready/wready/bvalid routed to d_*; SRAM signals ignored; d_bresp=0.
- LSU asserts arvalid and awvalid together → write serviced first (grant=10, op=WRITE); read granted next; i_* outputs stay 0 throughout.
- Slave never responds to an LSU read, TIMEOUT_CYCLES=8 → after 8 BUSY cycles grant=00 and d_rvalid=1, d_rresp=2'b11, d_rdata=0, held until d_rready; then IDLE.
- rstn pulled low while BUSY mid-read → grant=00 and all outputs 0 asynchronously; after release, a fresh IFU request is granted normally.
